// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a valid/ready handshake and a
// 2-entry skid buffer. Upstream ready is a flop output, so the downstream
// ready path never reaches the upstream port combinationally. Stall holds
// the stage contents and flush discards them; an empty stage drives
// NOP_VALUE. Occupancy and a saturating bubble counter support control
// and performance monitoring. Every output is taken straight from a flop.
module pipe_stage_skid #(
    parameter int unsigned     DW        = 32,
    parameter logic [DW-1:0]   NOP_VALUE = DW'(32'h00000013),
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    // upstream side
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    // pipeline control
    input  logic             stall_i,
    input  logic             flush_i,
    // downstream side
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_data_o,
    // monitoring
    output logic [1:0]       occupancy_o,
    input  logic             bubble_clr_i,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    // Main entry is what the downstream stage sees. The skid entry is only
    // occupied while main is occupied, and its payload is always younger.
    logic             main_valid_q, main_valid_d;
    logic [DW-1:0]    main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [DW-1:0]    skid_data_q,  skid_data_d;
    logic [1:0]       occupancy_q,  occupancy_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic acc;      // payload transferred from upstream this cycle
    logic eff_rdy;  // downstream may take the main entry this cycle
    logic cons;     // main entry leaves the stage this cycle

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Upstream may send exactly when the skid entry is free; because the
    // skid valid bit is a flop, so is the ready.
    assign in_ready_o = ~skid_valid_q;

    assign acc     = in_valid_i & in_ready_o;
    assign eff_rdy = out_ready_i & ~stall_i;
    assign cons    = main_valid_q & eff_rdy;

    // Next-state selection for both entries: flush, then fill-empty-main,
    // then consume (with refill from skid or input), then park into skid.
    always_comb begin
        // NOTE: every signal written in this block gets a default first, so
        // no path leaves a value unassigned and no latch is inferred.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            // Bubble insertion: everything in flight is dropped, including
            // any payload offered this very cycle. Stall plays no role.
            main_valid_d = 1'b0;
            main_data_d  = NOP_VALUE;
            skid_valid_d = 1'b0;
            skid_data_d  = NOP_VALUE;
        end else if (!main_valid_q) begin
            // Empty stage: an accepted payload goes straight to main. The
            // skid entry is empty here as well, so it needs no update.
            if (acc) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end
        end else if (cons) begin
            if (skid_valid_q) begin
                // Older parked payload advances; ready was low, so there is
                // no new payload to place this cycle.
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = NOP_VALUE;
            end else if (acc) begin
                // Back-to-back streaming: replace the departing entry.
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end else begin
                main_valid_d = 1'b0;
                main_data_d  = NOP_VALUE;
            end
        end else begin
            // Main is held (backpressure or stall). A payload accepted now
            // can only land in the skid entry, which is free whenever acc=1.
            if (acc) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end
    end

    // Occupancy is computed from the next entry state so the registered
    // count lines up with the valid bits it describes.
    always_comb begin
        occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // Bubble counter: clear wins over counting; counts cycles in which the
    // downstream side currently sees no valid entry, saturating at all-ones.
    // A flush intentionally leaves the count alone.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_clr_i) begin
            bubble_cnt_d = '0;
        end else if (!main_valid_q && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Entry valid bits and occupancy, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignments so every flop in
        // the design samples its next value from the same pre-edge state.
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            occupancy_q  <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            occupancy_q  <= occupancy_d;
        end
    end

    // Entry payloads. They are reset as well, because an empty entry must
    // present NOP_VALUE on the output immediately, not after a first edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: payload registers here carry an architecturally visible
        // reset value; plain storage arrays without such a need stay
        // unreset so they can map onto RAM.
        if (rst) begin
            main_data_q <= NOP_VALUE;
            skid_data_q <= NOP_VALUE;
        end else begin
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Saturating bubble counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid_o  = main_valid_q;
    assign out_data_o   = main_data_q;
    assign occupancy_o  = occupancy_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width ID/EX-style set-register pipeline stage. One generic stage register carries a DW-bit payload between any two core stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered and breaks the combinational ready path.
- Separates stall (hold contents) from flush (insert bubble). Emits NOP_VALUE whenever empty.
- Exposes occupancy and a saturating bubble counter for ctrl and performance monitoring.

Parameters:
- DW, 32, payload width in bits (≥1).
- NOP_VALUE, 32'h00000013, value driven on out_data_o when no valid entry is present; bubble payload (RV32 addi x0,x0,0); width DW.
- CNT_W, 16, bubble counter width (≥2).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid_i  input  1  upstream payload valid
- in_ready_o  output  1  stage can accept; registered, equals ~skid_valid
- in_data_i  input  DW  upstream payload
- stall_i  input  1  from ctrl: hold contents, block downstream transfer
- flush_i  input  1  from ctrl: discard all contents
- out_valid_o  output  1  main entry valid
- out_ready_i  input  1  downstream accepts
- out_data_o  output  DW  main entry payload, NOP_VALUE when not valid
- occupancy_o  output  2  number of valid entries, 0..2
- bubble_clr_i  input  1  synchronous clear of bubble counter
- bubble_cnt_o  output  CNT_W  cycles with out_valid_o=0, saturating

Behaviour:
- Reset (async, any time, including mid-transfer):
  - main_valid = 0, skid_valid = 0.
  - main_data = skid_data = NOP_VALUE.
  - in_ready_o = 1, out_valid_o = 0, out_data_o = NOP_VALUE, occupancy_o = 0, bubble_cnt_o = 0.
- Definitions:
  - acc = in_valid_i & in_ready_o
  - eff_rdy = out_ready_i & ~stall_i
  - cons = main_valid & eff_rdy
- Latency: a payload accepted in cycle N appears on out_data_o with out_valid_o=1 in cycle N+1 if main is empty or being consumed. Otherwise it goes to skid and reaches main the cycle after main is consumed.
- Next-state priority, highest first:
  1. flush_i=1: main_valid ← 0 and skid_valid ← 0; both data ← NOP_VALUE. Any acc in the same cycle is dropped. stall_i is ignored.
  2. main empty: if acc, main ← input.
  3. main valid and cons:
     - skid valid: main ← skid, skid ← empty. in_ready_o was 0, so no acc is possible.
     - skid empty: main ← input if acc, else main ← empty.
  4. main valid and not cons: if acc, skid ← input. This can only occur with skid empty.
- Invariants:
  - skid_valid=1 implies main_valid=1.
  - Order is preserved: main content is always older than skid content.
  - No payload is duplicated or lost except on flush.
- Emptying: when an entry becomes empty, its data register loads NOP_VALUE. out_data_o therefore equals NOP_VALUE whenever out_valid_o=0.
- Stall: stall_i=1 with flush_i=0 freezes the main entry, because cons=0.
  - Upstream may still fill skid while skid is empty. in_ready_o drops the cycle after.
- occupancy_o = main_valid + skid_valid, registered. The value 2 is reached only with in_ready_o=0.
- Bubble counter:
  - bubble_clr_i=1 sets the counter to 0 next cycle; clear has priority over increment.
  - Otherwise it increments when out_valid_o=0 in the current cycle and saturates at all-ones.
  - Flush does not clear the counter.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Reset then streaming: after reset, in_valid_i=1 with data 0x11,0x22,0x33 on consecutive cycles and out_ready_i=1 → outputs 0x11,0x22,0x33 one cycle later each; in_ready_o stays 1; occupancy_o=1.
- Backpressure/skid: main holds 0xA1 with out_ready_i=0, then 0xB2 is accepted → occupancy_o=2 and in_ready_o=0 next cycle. After out_ready_i=1, out_data_o shows 0xA1 then 0xB2, with in_ready_o=1 restored as 0xB2 moves to main.
- Stall: 0xC3 in main, stall_i=1 and out_ready_i=1 for 3 cycles → out_data_o=0xC3 and out_valid_o=1 throughout. Release → 0xC3 is consumed once.
- Flush with simultaneous input: both entries full (0xD4, 0xE5), then flush_i=1 together with in_valid_i=1 / 0xF6 → next cycle out_valid_o=0, out_data_o=0x00000013, occupancy_o=0, in_ready_o=1; 0xF6 never appears.
- Bubble counter with CNT_W=2: 5 idle cycles → bubble_cnt_o reads 1,2,3,3,3 (saturates at 3). bubble_clr_i=1 while idle → 0 next cycle.
- Async reset mid-stream: assert rst between clock edges while occupancy_o=2 → all outputs immediately at reset values, without waiting for an edge; after release, streaming resumes normally.
